aes_key_expander: RTL and testbench

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_key_expander_key_step.sv | 26 ++
 rtl/aes_key_expander.sv | 97 +++++++++
 tb/tb_aes_key_expander.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, FSM states and the
// GF(2^8) helpers used by the round-key transform.
package aes_pkg;

  localparam int         NR        = 10;
  localparam int         NK_BITS   = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Row r holds S-box entries 16r..16r+15, most significant byte first.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] pos;
    pos = {~b, 3'b000};
    return SBOX_TABLE[pos +: 8];
  endfunction

endpackage

// File: rtl/aes_key_expander_key_step.sv
// One AES-128 key-schedule round: derives round key r+1 from round key r.
module key_step
  import aes_pkg::*;
(
  input  logic [NK_BITS-1:0] key_in,
  input  logic [7:0]         rcon,
  output logic [NK_BITS-1:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] g;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_in;

  // SubWord(RotWord(W3)) with rcon folded into the leading byte
  assign g = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

  assign n0 = w0 ^ g;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key expander: streams round keys 0..10, one per cycle,
// and keeps the full schedule in a flop table with a registered read port.
module aes_key_expander
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NK_BITS-1:0] key_in,
  output logic               busy,
  output logic               rk_valid,
  output logic [3:0]         rk_idx,
  output logic [NK_BITS-1:0] rk_data,
  output logic               done,
  output logic               keys_valid,
  input  logic [3:0]         rd_idx,
  output logic [NK_BITS-1:0] rd_key
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t             state;
  logic [3:0]         round;
  logic [7:0]         rcon;
  logic [NK_BITS-1:0] work_key;
  logic [NK_BITS-1:0] next_key;
  logic [NK_BITS-1:0] key_table [0:NR];

  key_step u_key_step (
    .key_in  (work_key),
    .rcon    (rcon),
    .key_out (next_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rk_valid   <= 1'b0;
      keys_valid <= 1'b0;
      rk_idx     <= '0;
      rk_data    <= '0;
      round      <= '0;
      rcon       <= RCON_INIT;
      work_key   <= '0;
      for (int i = 0; i <= NR; i++) key_table[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            key_table[0] <= key_in;
            work_key     <= key_in;
            round        <= 4'd1;
            rcon         <= RCON_INIT;
            keys_valid   <= 1'b0;
            busy         <= 1'b1;
            rk_valid     <= 1'b1;
            rk_idx       <= '0;
            rk_data      <= key_in;
            state        <= EXPAND;
          end
        end
        EXPAND: begin
          key_table[round] <= next_key;
          work_key         <= next_key;
          rk_valid         <= 1'b1;
          rk_idx           <= round;
          rk_data          <= next_key;
          rcon             <= xtime(rcon);
          round            <= round + 4'd1;
          if (round == LAST_IDX) begin
            done       <= 1'b1;
            keys_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          // start is deliberately not sampled here
          done     <= 1'b0;
          rk_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read; a same-cycle table write is seen one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rd_key <= '0;
    else if (rd_idx <= LAST_IDX) rd_key <= key_table[rd_idx];
    else                         rd_key <= '0;
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: FIPS-197 key schedule model with
// a cycle timeline, per-cycle output comparison and directed scenarios.
module tb_aes_key_expander;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [127:0] key_in;
  logic [3:0]   rd_idx;
  logic         busy, rk_valid, done, keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data, rd_key;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  aes_key_expander dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .rk_valid   (rk_valid),
    .rk_idx     (rk_idx),
    .rk_data    (rk_data),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference AES-128 key schedule ----------------
  logic [7:0] sb [0:255];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic void expand_key(input logic [127:0] key, output logic [127:0] rk [0:10]);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- cycle timeline model ----------------
  // ph = 0 idle, 1..11 = cycle T+ph after an accepted start
  int           ph;
  logic         m_kv;
  logic [3:0]   m_idx;
  logic [127:0] m_data, exp_rd;
  logic [127:0] msched [0:10];
  logic [127:0] mtab   [0:10];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; m_kv = 1'b0; m_idx = 4'd0; m_data = '0; exp_rd = '0;
      for (int i = 0; i <= 10; i++) mtab[i] = '0;
    end else begin
      exp_rd = (rd_idx <= 4'd10) ? mtab[rd_idx] : '0;
      if (ph >= 1 && ph <= 10) begin
        mtab[ph] = msched[ph];
        ph++;
      end else if (ph == 11) begin
        ph = 0;
      end else if (start) begin
        expand_key(key_in, msched);
        mtab[0] = key_in;
        m_kv = 1'b0;
        ph = 1;
      end
      if (ph == 11) m_kv = 1'b1;
      if (ph >= 1 && ph <= 11) begin
        m_idx  = 4'(ph - 1);
        m_data = msched[ph - 1];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",       128'(busy),       128'(ph >= 1 && ph <= 11));
      chk("rk_valid",   128'(rk_valid),   128'(ph >= 1 && ph <= 11));
      chk("done",       128'(done),       128'(ph == 11));
      chk("keys_valid", 128'(keys_valid), 128'(m_kv));
      chk("rk_idx",     128'(rk_idx),     128'(m_idx));
      chk("rk_data",    rk_data,          m_data);
      chk("rd_key",     rd_key,           exp_rd);
    end
  end

  // ---------------- beat capture ----------------
  int           beats = 0;
  int           dones = 0;
  logic [127:0] cap      [0:15];
  logic         cap_done [0:15];

  always @(negedge clk) begin
    if (rk_valid === 1'b1) begin
      beats++;
      cap[rk_idx]      = rk_data;
      cap_done[rk_idx] = done;
    end
    if (done === 1'b1) dones++;
  end

  task automatic clear_caps();
    beats = 0; dones = 0;
    for (int i = 0; i < 16; i++) begin cap[i] = 'x; cap_done[i] = 1'bx; end
  endtask

  task automatic do_start(input logic [127:0] k);
    start = 1'b1; key_in = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [127:0] ref_rk [0:10];

  task automatic sweep(input string nm, input bit all_zero);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      @(negedge clk);
      chk(nm, rd_key, (all_zero || i > 10) ? 128'h0 : ref_rk[i]);
    end
    rd_idx = 4'd0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key_in = '0; rd_idx = 4'd0;
    build_sbox();

    expand_key(FIPS_KEY, ref_rk);
    chk("model_fips_r1",  ref_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_fips_r10", ref_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    expand_key(128'h0, ref_rk);
    chk("model_zero_r1",  ref_rk[1],  128'h62636363626363636263636362636363);
    chk("model_zero_r10", ref_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy",       128'(busy),       128'h0);
    chk("rst_rk_valid",   128'(rk_valid),   128'h0);
    chk("rst_done",       128'(done),       128'h0);
    chk("rst_keys_valid", 128'(keys_valid), 128'h0);
    chk("rst_rk_idx",     128'(rk_idx),     128'h0);
    chk("rst_rk_data",    rk_data,          128'h0);
    chk("rst_rd_key",     rd_key,           128'h0);

    // FIPS-197 key, start already high when reset releases
    clear_caps();
    start = 1'b1; key_in = FIPS_KEY;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("fips_r0",        cap[0],  FIPS_KEY);
    chk("fips_r1",        cap[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r10",       cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_r10_done",  128'(cap_done[10]), 128'h1);
    chk("fips_beats",     128'(beats), 128'd11);
    chk("fips_dones",     128'(dones), 128'd1);
    chk("fips_keys_valid", 128'(keys_valid), 128'h1);

    expand_key(FIPS_KEY, ref_rk);
    sweep("fips_sweep", 1'b0);

    // all-zero key with stray start pulses at T+3 and T+11
    clear_caps();
    do_start(128'h0);
    repeat (2) @(negedge clk);
    start = 1'b1; key_in = FIPS_KEY;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("zero_r1",         cap[1],  128'h62636363626363636263636362636363);
    chk("zero_r10",        cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("zero_beats",      128'(beats), 128'd11);
    chk("zero_dones",      128'(dones), 128'd1);
    chk("zero_keys_valid", 128'(keys_valid), 128'h1);
    chk("zero_busy_after", 128'(busy), 128'h0);

    // reset mid-expansion
    clear_caps();
    do_start(FIPS_KEY);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",     128'(busy),     128'h0);
    chk("abort_rk_valid", 128'(rk_valid), 128'h0);
    begin
      int beats_at;
      beats_at = beats;
      repeat (3) @(negedge clk);
      chk("abort_keys_valid", 128'(keys_valid), 128'h0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      sweep("abort_sweep", 1'b1);
      chk("abort_no_beats", 128'(beats), 128'(beats_at));
      chk("abort_no_done",  128'(dones), 128'h0);
      chk("abort_kv_idle",  128'(keys_valid), 128'h0);
    end

    // back-to-back expansions: start at T and T+12
    clear_caps();
    do_start(FIPS_KEY);
    repeat (11) @(negedge clk);
    do_start(KEY_B);
    chk("b2b_kv_T13", 128'(keys_valid), 128'h0);
    repeat (9) @(negedge clk);
    chk("b2b_kv_T22", 128'(keys_valid), 128'h0);
    @(negedge clk);
    chk("b2b_kv_T23", 128'(keys_valid), 128'h1);
    repeat (2) @(negedge clk);
    expand_key(KEY_B, ref_rk);
    chk("b2b_beats", 128'(beats), 128'd22);
    chk("b2b_dones", 128'(dones), 128'd2);
    chk("b2b_r0",    cap[0],  KEY_B);
    chk("b2b_r10",   cap[10], ref_rk[10]);
    sweep("b2b_sweep", 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
